// File: rtl/input_debouncer.sv
// Two-channel switch debouncer: 2-flop sync, stability counter, 4-state FSM.
// Ports: clk, rst, A_raw/B_raw in; A/B levels, A_rise/B_rise pulses out.
// Macro INPUT_DEBOUNCER_RISE_PULSE_EN enables the rise pulses (else tied 0).
// Params: STABLE_COUNT (samples to qualify), CNT_WIDTH (counter width).

module input_debouncer_chan #(
  parameter int unsigned STABLE_COUNT = 1000000,
  parameter int unsigned CNT_WIDTH    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  logic                 s1_q;
  logic                 s2_q;
  state_e               state_q;
  state_e               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 out_q;
  logic                 out_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Counter defaults to 0 so it is always 0 in the IDLE states.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    out_d   = out_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_HIGH;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = ONE;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_LOW;
          out_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
      end
    endcase
  end

  assign lvl_o = out_q;

`ifdef INPUT_DEBOUNCER_RISE_PULSE_EN
  logic rise_q;

  // Pulse in the cycle after the output register goes 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
    end
  end

  assign rise_o = rise_q;
`else
  assign rise_o = 1'b0;
`endif

endmodule

module input_debouncer #(
  parameter int unsigned STABLE_COUNT = 1000000,
  parameter int unsigned CNT_WIDTH    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic A_raw,
  input  logic B_raw,
  output logic A,
  output logic B,
  output logic A_rise,
  output logic B_rise
);

  input_debouncer_chan #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw_i (A_raw),
    .lvl_o (A),
    .rise_o(A_rise)
  );

  input_debouncer_chan #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw_i (B_raw),
    .lvl_o (B),
    .rise_o(B_rise)
  );

endmodule
